draw_cmd_mux: RTL and testbench



---
 rtl/draw_cmd_mux_pkg.sv | 23 ++
 rtl/draw_cmd_mux_if.sv | 23 ++
 rtl/draw_cmd_fifo.sv | 64 ++++++
 rtl/draw_cmd_mux.sv | 132 +++++++++++++
 tb/tb_draw_cmd_mux.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/draw_cmd_mux_pkg.sv
// Shared definitions for the draw-command merger: command width, opcodes,
// producer channel assignment and the arbiter state encoding.
package draw_cmd_pkg;

   localparam int CMD_WIDTH = 32;

   // Opcode lives in cmd[31:28]
   localparam logic [3:0] OP_POINT = 4'h0;
   localparam logic [3:0] OP_RECT  = 4'h1;
   localparam logic [3:0] OP_LINE  = 4'h9;
   localparam logic [3:0] OP_CHAR  = 4'ha;

   localparam int CH_INIT  = 0;
   localparam int CH_BODY  = 1;
   localparam int CH_SCORE = 2;
   localparam int CH_PREY  = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } mux_state_t;

endpackage

// File: rtl/draw_cmd_mux_if.sv
// Producer-side and draw-engine-side handshake bundle for draw_cmd_mux.
interface draw_cmd_mux_if #(
   parameter int NUM_CH    = 4,
   parameter int CMD_WIDTH = draw_cmd_pkg::CMD_WIDTH
);
   logic [NUM_CH*CMD_WIDTH-1:0] in_cmd;
   logic [NUM_CH-1:0]           in_last;
   logic [NUM_CH-1:0]           in_vld;
   logic [NUM_CH-1:0]           in_rdy;
   logic [CMD_WIDTH-1:0]        cmd;
   logic                        cmd_vld;
   logic                        cmd_rdy;

   modport master (
      output in_cmd, in_last, in_vld, cmd_rdy,
      input  in_rdy, cmd, cmd_vld
   );

   modport slave (
      input  in_cmd, in_last, in_vld, cmd_rdy,
      output in_rdy, cmd, cmd_vld
   );
endinterface

// File: rtl/draw_cmd_fifo.sv
// Per-channel synchronous FIFO with full/empty/level; a full FIFO never
// accepts a write, even when it is popped in the same cycle.
module draw_cmd_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic [AW:0]      level
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             push, pop;

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign level   = cnt_q;
   assign rd_data = mem_q[rd_ptr_q];
   assign push    = wr_en & ~full;
   assign pop     = rd_en & ~empty;

   // NOTE: every variable gets a default before any branch so no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // NOTE: state flops use non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // NOTE: storage is not reset; the pointers and count alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/draw_cmd_mux.sv
// Multi-source draw-command merger: per-channel FIFOs, round-robin group
// arbitration, and a registered output. Define DRAW_CMD_MUX_PRIO0_EN to let
// channel 0 win every grant decision it is pending for.
module draw_cmd_mux
   import draw_cmd_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int CMD_WIDTH  = draw_cmd_pkg::CMD_WIDTH,
   parameter int FIFO_DEPTH = 8,
   parameter int FIFO_AW    = 3,
   parameter int CH_W       = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enb,
   draw_cmd_mux_if.slave     bus,
   output logic [CH_W-1:0]   grant_ch,
   output logic [NUM_CH-1:0] ch_pend
);

   logic [NUM_CH-1:0]    full, empty, pop;
   logic [FIFO_AW:0]     level [NUM_CH];
   logic [CMD_WIDTH:0]   head  [NUM_CH];

   mux_state_t           state_q, state_d;
   logic [CH_W-1:0]      grant_q, grant_d;
   logic [CH_W-1:0]      ptr_q, ptr_d;
   logic [CMD_WIDTH-1:0] cmd_q, cmd_d;
   logic                 cmd_vld_q, cmd_vld_d;

   logic                 load, do_pop, found;
   logic [CH_W-1:0]      sel, pick, idx;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      draw_cmd_fifo #(
         .WIDTH (CMD_WIDTH + 1),
         .DEPTH (FIFO_DEPTH),
         .AW    (FIFO_AW)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .wr_en   (bus.in_vld[i]),
         .wr_data ({bus.in_last[i], bus.in_cmd[i*CMD_WIDTH +: CMD_WIDTH]}),
         .full    (full[i]),
         .rd_en   (pop[i]),
         .rd_data (head[i]),
         .empty   (empty[i]),
         .level   (level[i])
      );
      assign ch_pend[i] = (level[i] != '0);
   end

   assign bus.in_rdy  = ~full;
   assign bus.cmd     = cmd_q;
   assign bus.cmd_vld = cmd_vld_q;
   assign grant_ch    = grant_q;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      cmd_d     = cmd_q;
      cmd_vld_d = cmd_vld_q;
      pop       = '0;
      do_pop    = 1'b0;
      found     = 1'b0;
      pick      = '0;
      idx       = '0;
      sel       = grant_q;
      load      = ~cmd_vld_q | bus.cmd_rdy;

      if (load) cmd_vld_d = 1'b0;

      // Search starts just after the last granted channel and wraps.
`ifdef DRAW_CMD_MUX_PRIO0_EN
      if (!empty[0]) begin
         found = 1'b1;
         pick  = '0;
      end
`endif
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = CH_W'((int'(ptr_q) + k) % NUM_CH);
         if (!found && !empty[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (enb && load && found) begin
               do_pop  = 1'b1;
               sel     = pick;
               grant_d = pick;
               ptr_d   = pick;
            end
         end
         ST_LOCK: begin
            // The owner keeps the output until its last word, even if it stalls.
            if (load && !empty[grant_q]) begin
               do_pop = 1'b1;
               sel    = grant_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (do_pop) begin
         pop[sel]  = 1'b1;
         cmd_d     = head[sel][CMD_WIDTH-1:0];
         cmd_vld_d = 1'b1;
         state_d   = head[sel][CMD_WIDTH] ? ST_IDLE : ST_LOCK;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         ptr_q     <= CH_W'(NUM_CH - 1);
         cmd_q     <= '0;
         cmd_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         cmd_q     <= cmd_d;
         cmd_vld_q <= cmd_vld_d;
      end
   end

endmodule

// File: tb/tb_draw_cmd_mux.sv
// Self-checking bench for draw_cmd_mux: scoreboard of expected output words
// plus per-scenario checks of latency, grants, backpressure and reset.
module tb_draw_cmd_mux;
   import draw_cmd_pkg::*;

   localparam int NCH = 4;

   typedef struct packed {
      logic [31:0] cmd;
      logic [1:0]  ch;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       enb;
   logic [1:0] grant_ch;
   logic [3:0] ch_pend;

   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];

   draw_cmd_mux_if #(.NUM_CH(NCH), .CMD_WIDTH(32)) bus ();

   draw_cmd_mux #(
      .NUM_CH(NCH), .CMD_WIDTH(32), .FIFO_DEPTH(8), .FIFO_AW(3), .CH_W(2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .enb      (enb),
      .bus      (bus),
      .grant_ch (grant_ch),
      .ch_pend  (ch_pend)
   );

   always #5 clk = ~clk;

   // Handshake values seen at the negedge are the ones captured at the next posedge.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.cmd_vld && bus.cmd_rdy) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got cmd=%h ch=%0d, expected no output", bus.cmd, grant_ch);
         end else begin
            e = exp_q.pop_front();
            if (bus.cmd !== e.cmd || grant_ch !== e.ch)
               begin
                  errors++;
                  $display("FAIL scoreboard: got cmd=%h ch=%0d, expected cmd=%h ch=%0d",
                           bus.cmd, grant_ch, e.cmd, e.ch);
               end
         end
      end
   end

   task automatic push(input int ch, input logic [31:0] data, input logic last);
      int n = 0;
      bus.in_vld[ch] = 1'b1;
      bus.in_cmd[ch*32 +: 32] = data;
      bus.in_last[ch] = last;
      while (!bus.in_rdy[ch] && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n >= 50) begin
         errors++;
         $display("FAIL push_timeout: ch%0d in_rdy stayed %b, expected 1", ch, bus.in_rdy[ch]);
      end
      @(posedge clk); #1;
      bus.in_vld[ch] = 1'b0;
   endtask

   task automatic exp_push(input logic [31:0] data, input int ch);
      exp_t e;
      e.cmd = data;
      e.ch  = 2'(ch);
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.cmd !== 32'h0 || bus.cmd_vld !== 1'b0 || grant_ch !== 2'd0 ||
          ch_pend !== 4'h0 || bus.in_rdy !== 4'hf) begin
         errors++;
         $display("FAIL reset_values: cmd=%h vld=%b grant=%0d pend=%h rdy=%h, expected 0 0 0 0 f",
                  bus.cmd, bus.cmd_vld, grant_ch, ch_pend, bus.in_rdy);
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      logic [31:0] a = {OP_CHAR, 28'h0000_a01};
      logic [31:0] b = {OP_CHAR, 28'h0000_b02};
      enb = 1'b1;
      bus.cmd_rdy = 1'b1;
      exp_push(a, CH_BODY);
      exp_push(b, CH_BODY);
      push(CH_BODY, a, 1'b0);
      push(CH_BODY, b, 1'b1);
      checks++;
      if (bus.cmd_vld !== 1'b1 || bus.cmd !== a || grant_ch !== 2'd1) begin
         errors++;
         $display("FAIL single_first_latency: vld=%b cmd=%h grant=%0d, expected 1 %h 1",
                  bus.cmd_vld, bus.cmd, grant_ch, a);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.cmd_vld !== 1'b1 || bus.cmd !== b) begin
         errors++;
         $display("FAIL single_second: vld=%b cmd=%h, expected 1 %h", bus.cmd_vld, bus.cmd, b);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.cmd_vld !== 1'b0) begin
         errors++;
         $display("FAIL single_idle_after: vld=%b, expected 0", bus.cmd_vld);
      end
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d words still expected, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      bus.cmd_rdy = 1'b1;
      for (int set = 0; set < 2; set++) begin
         enb = 1'b0;
         for (int c = 0; c < NCH; c++) push(c, {OP_POINT, 20'h0, 4'(set), 4'(c)}, 1'b1);
         repeat (2) @(posedge clk);
         #1;
         checks++;
         if (ch_pend !== 4'hf || bus.cmd_vld !== 1'b0) begin
            errors++;
            $display("FAIL rr_preload_set%0d: pend=%h vld=%b, expected f 0", set, ch_pend, bus.cmd_vld);
         end
         for (int c = 0; c < NCH; c++) exp_push({OP_POINT, 20'h0, 4'(set), 4'(c)}, c);
         enb = 1'b1;
         drain("round_robin");
      end
   endtask

   task automatic test_atomicity();
      logic [31:0] w1 = {OP_CHAR, 28'h2_0001};
      logic [31:0] w2 = {OP_CHAR, 28'h2_0002};
      logic [31:0] v  = {OP_RECT, 28'h3_0001};
      enb = 1'b1;
      bus.cmd_rdy = 1'b1;
      exp_push(w1, CH_SCORE);
      push(CH_SCORE, w1, 1'b0);
      push(CH_PREY, v, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (bus.cmd_vld !== 1'b0 || grant_ch !== 2'd2 || ch_pend !== 4'b1000) begin
         errors++;
         $display("FAIL atomic_hold: vld=%b grant=%0d pend=%b, expected 0 2 1000",
                  bus.cmd_vld, grant_ch, ch_pend);
      end
      exp_push(w2, CH_SCORE);
      exp_push(v, CH_PREY);
      push(CH_SCORE, w2, 1'b1);
      drain("atomicity");
   endtask

   task automatic test_backpressure();
      logic [31:0] base = {OP_LINE, 28'h000_0100};
      int acc = 0;
      logic took;
      do_reset();
      enb = 1'b1;
      bus.cmd_rdy = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (acc < 10) begin
            bus.in_vld[0] = 1'b1;
            bus.in_cmd[31:0] = base + 32'(acc);
            bus.in_last[0] = 1'b1;
         end else begin
            bus.in_vld[0] = 1'b0;
         end
         took = bus.in_vld[0] && bus.in_rdy[0];
         @(posedge clk); #1;
         if (took) begin
            exp_push(base + 32'(acc), 0);
            acc++;
         end
         if (c == 3) begin
            checks++;
            if (bus.cmd_vld !== 1'b1 || bus.cmd !== base) begin
               errors++;
               $display("FAIL bp_early_hold: vld=%b cmd=%h, expected 1 %h", bus.cmd_vld, bus.cmd, base);
            end
         end
      end
      bus.in_vld[0] = 1'b0;
      checks++;
      if (acc != 9 || bus.in_rdy[0] !== 1'b0) begin
         errors++;
         $display("FAIL bp_full: accepted=%0d in_rdy=%b, expected 9 0", acc, bus.in_rdy[0]);
      end
      checks++;
      if (bus.cmd_vld !== 1'b1 || bus.cmd !== base || ch_pend[0] !== 1'b1) begin
         errors++;
         $display("FAIL bp_late_hold: vld=%b cmd=%h pend0=%b, expected 1 %h 1",
                  bus.cmd_vld, bus.cmd, ch_pend[0], base);
      end
      bus.cmd_rdy = 1'b1;
      exp_push(base + 32'd9, 0);
      push(0, base + 32'd9, 1'b1);
      drain("backpressure");
   endtask

   task automatic test_reset_mid_and_enb();
      logic [31:0] a = {OP_CHAR, 28'h1_00aa};
      logic [31:0] c = {OP_RECT, 28'h0_00cc};
      logic [31:0] d = {OP_POINT, 28'h3_00dd};
      do_reset();
      enb = 1'b1;
      bus.cmd_rdy = 1'b1;
      exp_push(a, CH_BODY);
      push(CH_BODY, a, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      push(CH_INIT, c, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.cmd_vld !== 1'b0 || grant_ch !== 2'd1 || ch_pend !== 4'b0001) begin
         errors++;
         $display("FAIL lock_blocks_other: vld=%b grant=%0d pend=%b, expected 0 1 0001",
                  bus.cmd_vld, grant_ch, ch_pend);
      end
      do_reset();
      checks++;
      if (bus.cmd !== 32'h0 || bus.cmd_vld !== 1'b0 || grant_ch !== 2'd0 ||
          ch_pend !== 4'h0 || bus.in_rdy !== 4'hf) begin
         errors++;
         $display("FAIL reset_mid_group: cmd=%h vld=%b grant=%0d pend=%h rdy=%h, expected 0 0 0 0 f",
                  bus.cmd, bus.cmd_vld, grant_ch, ch_pend, bus.in_rdy);
      end
      enb = 1'b0;
      push(CH_PREY, d, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (bus.cmd_vld !== 1'b0 || ch_pend !== 4'b1000) begin
         errors++;
         $display("FAIL enb_low_hold: vld=%b pend=%b, expected 0 1000", bus.cmd_vld, ch_pend);
      end
      exp_push(d, CH_PREY);
      enb = 1'b1;
      drain("enb_release");
   endtask

   task automatic test_prio();
      logic [31:0] x = {OP_POINT, 28'h0_0001};
      logic [31:0] y = {OP_RECT,  28'h1_0002};
      logic [31:0] z = {OP_RECT,  28'h0_0003};
      do_reset();
      enb = 1'b1;
      bus.cmd_rdy = 1'b1;
      exp_push(x, CH_INIT);
      push(CH_INIT, x, 1'b1);
      drain("prio_setup");
      enb = 1'b0;
      push(CH_BODY, y, 1'b1);
      push(CH_INIT, z, 1'b1);
      repeat (2) @(posedge clk);
      #1;
`ifdef DRAW_CMD_MUX_PRIO0_EN
      exp_push(z, CH_INIT);
      exp_push(y, CH_BODY);
`else
      exp_push(y, CH_BODY);
      exp_push(z, CH_INIT);
`endif
      enb = 1'b1;
      drain("prio");
   endtask

   initial begin
      rst = 1'b1;
      enb = 1'b0;
      bus.in_cmd  = '0;
      bus.in_last = '0;
      bus.in_vld  = '0;
      bus.cmd_rdy = 1'b1;
      @(posedge clk); #1;

      test_reset();
      test_single();
      test_round_robin();
      test_atomicity();
      test_backpressure();
      test_reset_mid_and_enb();
      test_prio();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
